// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pkg
// Brief   : Shared types, widths and helpers for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  localparam int ADDR_WIDTH  = 5;
  localparam int MDU_LAT_MIN = 2;
  localparam int MDU_LAT_MAX = 16;
  localparam int MDU_CNT_W   = 4;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MDU_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_MEM      = 3'd1,
    HZ_MDU      = 3'd2,
    HZ_REDIRECT = 3'd3,
    HZ_LOAD_USE = 3'd4
  } hz_cause_e;

  // Only the highest-priority active hazard is allowed to steer the pipeline.
  function automatic hz_cause_e hz_select(input logic mem, input logic mdu,
                                          input logic redir, input logic lu);
    if (mem)        return HZ_MEM;
    else if (mdu)   return HZ_MDU;
    else if (redir) return HZ_REDIRECT;
    else if (lu)    return HZ_LOAD_USE;
    else            return HZ_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Brief   : Pipeline status inputs and stage-register controls of hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  import hazard_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr;
  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr;
  logic                  ID_Rs1_Used;
  logic                  ID_Rs2_Used;
  logic [ADDR_WIDTH-1:0] EX_Rd_Addr;
  logic                  EX_Mem_r;
  logic                  EX_Branch_Taken;
  logic                  EX_Mdu_Start;
  logic                  MEM_Mem_Access;
  logic                  Dmem_Ready;

  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  ID_EX_Write;
  logic                  EX_MEM_Write;
  logic                  MEM_WB_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic                  EX_MEM_Bubble;
  logic                  MEM_WB_Bubble;
  logic                  Mdu_Done;
  logic [CNT_WIDTH-1:0]  Stall_Cnt;
  logic [CNT_WIDTH-1:0]  Flush_Cnt;

  modport master (
    output ID_Rs1_Addr, ID_Rs2_Addr, ID_Rs1_Used, ID_Rs2_Used, EX_Rd_Addr,
           EX_Mem_r, EX_Branch_Taken, EX_Mdu_Start, MEM_Mem_Access, Dmem_Ready,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, MEM_WB_Bubble, Mdu_Done,
           Stall_Cnt, Flush_Cnt
  );

  modport slave (
    input  ID_Rs1_Addr, ID_Rs2_Addr, ID_Rs1_Used, ID_Rs2_Used, EX_Rd_Addr,
           EX_Mem_r, EX_Branch_Taken, EX_Mdu_Start, MEM_Mem_Access, Dmem_Ready,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, MEM_WB_Bubble, Mdu_Done,
           Stall_Cnt, Flush_Cnt
  );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mdu_stall_timer.sv
`default_nettype none
// ============================================================================
// Module  : mdu_stall_timer
// Brief   : Tracks a multi-cycle MDU op in EX; raises stall and a one-cycle done.
// Revision: 1.0 - initial release
// ============================================================================
module mdu_stall_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_mdu_start,
  input  wire logic i_mem_stall,
  output logic      o_mdu_stall,
  output logic      o_mdu_done
);

  localparam logic [MDU_CNT_W-1:0] C_CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

  hz_state_e            r_state;
  hz_state_e            w_state_nxt;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [MDU_CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A data-memory stall freezes the op: the countdown and the done pulse wait.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mdu_stall = 1'b0;
    o_mdu_done  = 1'b0;
    case (r_state)
      HZ_RUN: begin
        o_mdu_stall = i_mdu_start;
        if (i_mdu_start && !i_mem_stall) begin
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = HZ_MDU_WAIT;
        end
      end
      HZ_MDU_WAIT: begin
        if (r_cnt != '0) begin
          o_mdu_stall = 1'b1;
          if (!i_mem_stall) w_cnt_nxt = r_cnt - 1'b1;
        end else if (!i_mem_stall) begin
          o_mdu_done  = 1'b1;
          w_state_nxt = HZ_RUN;
        end
      end
      default: w_state_nxt = HZ_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Priority hazard resolver driving pipeline register enables/flushes.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  hazard_ctrl_if.slave hz
);

  logic                 w_mem_stall;
  logic                 w_mdu_stall;
  logic                 w_mdu_done;
  logic                 w_load_use;
  hz_cause_e            w_cause;
  logic                 w_pc_write, w_if_id_write, w_id_ex_write;
  logic                 w_ex_mem_write, w_mem_wb_write;
  logic                 w_if_id_flush, w_id_ex_flush;
  logic                 w_ex_mem_bubble, w_mem_wb_bubble;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  assign w_mem_stall = hz.MEM_Mem_Access & ~hz.Dmem_Ready;

  assign w_load_use = hz.EX_Mem_r && (hz.EX_Rd_Addr != '0) &&
                      ((hz.ID_Rs1_Used && (hz.EX_Rd_Addr == hz.ID_Rs1_Addr)) ||
                       (hz.ID_Rs2_Used && (hz.EX_Rd_Addr == hz.ID_Rs2_Addr)));

  mdu_stall_timer #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_timer (
    .clk         (clk),
    .rst         (rst),
    .i_mdu_start (hz.EX_Mdu_Start),
    .i_mem_stall (w_mem_stall),
    .o_mdu_stall (w_mdu_stall),
    .o_mdu_done  (w_mdu_done)
  );

  assign w_cause = hz_select(w_mem_stall, w_mdu_stall, hz.EX_Branch_Taken, w_load_use);

  // Reset forces a free-running pipeline with no flushes or bubbles.
  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_ex_mem_write  = 1'b1;
    w_mem_wb_write  = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mem_wb_bubble = 1'b0;
    if (!rst) begin
      case (w_cause)
        HZ_MEM: begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_write  = 1'b0;
          w_mem_wb_bubble = 1'b1;
        end
        HZ_MDU: begin
          w_pc_write      = 1'b0;
          w_if_id_write   = 1'b0;
          w_id_ex_write   = 1'b0;
          w_ex_mem_bubble = 1'b1;
        end
        HZ_REDIRECT: begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end
        HZ_LOAD_USE: begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write)                   r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_if_id_flush | w_id_ex_flush) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.PC_Write      = w_pc_write;
  assign hz.IF_ID_Write   = w_if_id_write;
  assign hz.ID_EX_Write   = w_id_ex_write;
  assign hz.EX_MEM_Write  = w_ex_mem_write;
  assign hz.MEM_WB_Write  = w_mem_wb_write;
  assign hz.IF_ID_Flush   = w_if_id_flush;
  assign hz.ID_EX_Flush   = w_id_ex_flush;
  assign hz.EX_MEM_Bubble = w_ex_mem_bubble;
  assign hz.MEM_WB_Bubble = w_mem_wb_bubble;
  assign hz.Mdu_Done      = w_mdu_done & ~rst;
  assign hz.Stall_Cnt     = r_stall_cnt;
  assign hz.Flush_Cnt     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Scoreboard bench for hazard_ctrl against a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int LAT = 4;
  localparam int CW  = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       memr;
    logic       br;
    logic       mdu;
    logic       macc;
    logic       rdy;
  } stim_t;

  // {PC, IF/ID, ID/EX, EX/MEM, MEM/WB writes, IF/ID flush, ID/EX flush,
  //  EX/MEM bubble, MEM/WB bubble, Mdu_Done}
  typedef struct packed {
    logic [9:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(CW)) ifc ();

  hazard_ctrl #(
    .MDU_LATENCY (LAT),
    .CNT_WIDTH   (CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (ifc.slave)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int   m_mdu_left = 0;
  int   m_stall    = 0;
  int   m_flush    = 0;

  task automatic drive(input stim_t s);
    exp_t e;
    bit   mem, mstall, lu, pcw, fl;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    ifc.ID_Rs1_Addr     = s.rs1;
    ifc.ID_Rs2_Addr     = s.rs2;
    ifc.ID_Rs1_Used     = s.u1;
    ifc.ID_Rs2_Used     = s.u2;
    ifc.EX_Rd_Addr      = s.rd;
    ifc.EX_Mem_r        = s.memr;
    ifc.EX_Branch_Taken = s.br;
    ifc.EX_Mdu_Start    = s.mdu;
    ifc.MEM_Mem_Access  = s.macc;
    ifc.Dmem_Ready      = s.rdy;

    mem    = s.macc && !s.rdy;
    mstall = (m_mdu_left == 0 && s.mdu) || (m_mdu_left > 1);
    lu     = s.memr && s.rd != 0 && ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
    if (s.rst) begin
      m_mdu_left = 0;
      m_stall    = 0;
      m_flush    = 0;
      e.ctl = 10'b11111_0000_0;
    end else if (mem)       e.ctl = 10'b00001_0001_0;
    else if (mstall)        e.ctl = 10'b00011_0010_0;
    else if (s.br)          e.ctl = 10'b11111_1100_0;
    else if (lu)            e.ctl = 10'b00111_0100_0;
    else                    e.ctl = 10'b11111_0000_0;
    if (!s.rst && m_mdu_left == 1 && !mem) e.ctl[0] = 1'b1;
    e.sc = CW'(m_stall);
    e.fc = CW'(m_flush);
    exp_q.push_back(e);

    if (!s.rst) begin
      pcw = e.ctl[9];
      fl  = e.ctl[4] | e.ctl[3];
      if (!pcw) m_stall = (m_stall + 1) % (1 << CW);
      if (fl)   m_flush = (m_flush + 1) % (1 << CW);
      if (m_mdu_left == 0) begin
        if (s.mdu && !mem) m_mdu_left = LAT - 1;
      end else if (!mem) begin
        m_mdu_left = m_mdu_left - 1;
      end
    end
  endtask

  function automatic stim_t st(input bit memr, input bit [4:0] rd, input bit [4:0] rs1,
                               input bit br, input bit mdu, input bit macc, input bit rdy);
    stim_t s;
    s      = '0;
    s.memr = memr;
    s.rd   = rd;
    s.rs1  = rs1;
    s.u1   = 1'b1;
    s.rs2  = 5'd31;
    s.br   = br;
    s.mdu  = mdu;
    s.macc = macc;
    s.rdy  = rdy;
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [9:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {ifc.PC_Write, ifc.IF_ID_Write, ifc.ID_EX_Write, ifc.EX_MEM_Write,
             ifc.MEM_WB_Write, ifc.IF_ID_Flush, ifc.ID_EX_Flush, ifc.EX_MEM_Bubble,
             ifc.MEM_WB_Bubble, ifc.Mdu_Done};
      n_vec++;
      if (act !== e.ctl || ifc.Stall_Cnt !== e.sc || ifc.Flush_Cnt !== e.fc) begin
        n_err++;
        $display("FAIL vec%0d t=%0t ctl got %b exp %b, stall_cnt got %0d exp %0d, flush_cnt got %0d exp %0d",
                 n_vec, $time, act, e.ctl, ifc.Stall_Cnt, e.sc, ifc.Flush_Cnt, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    rst   = 1'b1;
    ifc.ID_Rs1_Addr = '0; ifc.ID_Rs2_Addr = '0; ifc.ID_Rs1_Used = 1'b0;
    ifc.ID_Rs2_Used = 1'b0; ifc.EX_Rd_Addr = '0; ifc.EX_Mem_r = 1'b0;
    ifc.EX_Branch_Taken = 1'b0; ifc.EX_Mdu_Start = 1'b0;
    ifc.MEM_Mem_Access = 1'b0; ifc.Dmem_Ready = 1'b1;
    repeat (2) drive(s);
    repeat (2) drive(st(0, 0, 0, 0, 0, 0, 1));

    // load-use on x5, then the same shape on x0
    drive(st(1, 5, 5, 0, 0, 0, 1));
    drive(st(0, 5, 5, 0, 0, 0, 1));
    drive(st(1, 0, 0, 0, 0, 0, 1));
    drive(st(0, 0, 0, 0, 0, 0, 1));

    // MDU op held in EX until its done cycle, then a back-to-back op
    repeat (LAT) drive(st(0, 0, 0, 0, 1, 0, 1));
    repeat (LAT) drive(st(0, 0, 0, 0, 1, 0, 1));
    drive(st(0, 0, 0, 0, 0, 0, 1));

    // memory wait of two cycles inside MDU_WAIT
    drive(st(0, 0, 0, 0, 1, 0, 1));
    drive(st(0, 0, 0, 0, 1, 0, 1));
    repeat (2) drive(st(0, 0, 0, 0, 1, 1, 0));
    repeat (LAT) drive(st(0, 0, 0, 0, 1, 1, 1));
    drive(st(0, 0, 0, 0, 0, 0, 1));

    // taken branch coinciding with a load-use
    drive(st(1, 7, 7, 1, 0, 0, 1));
    drive(st(0, 0, 0, 0, 0, 0, 1));

    // reset in the middle of an MDU op
    drive(st(0, 0, 0, 0, 1, 0, 1));
    drive(st(0, 0, 0, 0, 1, 0, 1));
    s = st(0, 0, 0, 0, 1, 0, 1);
    s.rst = 1'b1;
    drive(s);
    drive(st(0, 0, 0, 0, 0, 0, 1));

    // 17 stall cycles wrap the 4-bit stall counter
    repeat (17) drive(st(0, 0, 0, 0, 0, 1, 0));
    repeat (2) drive(st(0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < 3000; i++) begin
      s      = '0;
      s.rst  = ($urandom_range(0, 199) == 0);
      s.rs1  = 5'($urandom_range(0, 7));
      s.rs2  = 5'($urandom_range(0, 7));
      s.u1   = $urandom_range(0, 1) == 1;
      s.u2   = $urandom_range(0, 1) == 1;
      s.rd   = 5'($urandom_range(0, 7));
      s.memr = ($urandom_range(0, 9) < 3);
      s.br   = ($urandom_range(0, 9) == 0);
      s.mdu  = ($urandom_range(0, 9) < 2);
      s.macc = ($urandom_range(0, 9) < 3);
      s.rdy  = ($urandom_range(0, 9) < 7);
      drive(s);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside the forwarding logic and drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four hazard classes in a fixed priority: data-memory wait, multi-cycle MDU, taken-branch redirect, and load-use. It also keeps stall and flush performance counters.

## Interface
- MDU_LATENCY, 4: total EX-stage cycles of a multi-cycle MUL/DIV op; legal range 2..16.
- CNT_WIDTH, 32: width of the performance counters.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ID_Rs1_Addr, ID_Rs2_Addr  in  `ADDR_WIDTH  source register addresses of the instruction in ID.
- ID_Rs1_Used, ID_Rs2_Used  in  1  the instruction in ID actually reads that source.
- EX_Rd_Addr  in  `ADDR_WIDTH  destination register of the instruction in EX.
- EX_Mem_r  in  1  the instruction in EX is a load.
- EX_Branch_Taken  in  1  a branch or jump resolved taken in EX.
- EX_Mdu_Start  in  1  the instruction in EX is a multi-cycle MDU op.
- MEM_Mem_Access  in  1  the instruction in MEM accesses data memory.
- Dmem_Ready  in  1  data memory completes the access this cycle.
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write  out  1  register load enables.
- IF_ID_Flush, ID_EX_Flush  out  1  the register loads a NOP.
- EX_MEM_Bubble, MEM_WB_Bubble  out  1  the register loads a NOP.
- Mdu_Done  out  1  MDU result is valid in EX this cycle.
- Stall_Cnt, Flush_Cnt  out  CNT_WIDTH  performance counters.

## Operation
Hazard terms:
- Mem_Stall = MEM_Mem_Access & !Dmem_Ready.
- Mdu_Stall = (state==RUN & EX_Mdu_Start) | (state==MDU_WAIT & cnt!=0).
- Redirect = EX_Branch_Taken.
- Load_Use = EX_Mem_r & EX_Rd_Addr!=0 & ((ID_Rs1_Used & EX_Rd_Addr==ID_Rs1_Addr) | (ID_Rs2_Used & EX_Rd_Addr==ID_Rs2_Addr)).

Only the highest-priority active term acts; the lower terms are ignored that cycle.
- Mem_Stall: PC, IF/ID, ID/EX and EX/MEM writes = 0. MEM_WB_Bubble = 1.
- Mdu_Stall: PC, IF/ID and ID/EX writes = 0. EX_MEM_Bubble = 1.
- Redirect: IF_ID_Flush = 1 and ID_EX_Flush = 1. All writes = 1. Load_Use in the same cycle is suppressed, because its ID instruction is being flushed.
- Load_Use: PC_Write = 0 and IF_ID_Write = 0. ID_EX_Flush = 1.
- No hazard: all writes = 1; all flushes and bubbles = 0.

FSM (states RUN and MDU_WAIT; cnt is 4 bits):
- RUN: if EX_Mdu_Start & !Mem_Stall, then cnt <= MDU_LATENCY-2 and the state goes to MDU_WAIT.
- MDU_WAIT: if Mem_Stall, cnt holds. Else if cnt!=0, cnt decrements. Else (cnt==0) Mdu_Done = 1 and the state goes to RUN.
- EX_Mdu_Start is ignored while in MDU_WAIT, so the same op is never restarted.
- Mdu_Done is combinational, gated by !Mem_Stall, and asserted for exactly one cycle.

Counters:
- Stall_Cnt increments on every cycle with PC_Write==0.
- Flush_Cnt increments on every cycle with IF_ID_Flush | ID_EX_Flush.
- Both wrap modulo 2^CNT_WIDTH.

## Timing
- Reset: state = RUN, cnt = 0, both counters = 0.
- While rst is high, outputs are forced to: all writes = 1, all flushes and bubbles = 0, Mdu_Done = 0. Reset asserted mid-MDU abandons the op.
- All control outputs are combinational from inputs and state; there is no added latency.
- MDU op entering EX in cycle t:
  - Mdu_Stall is high in cycles t .. t+MDU_LATENCY-2.
  - Mdu_Done is high in cycle t+MDU_LATENCY-1.
  - Each Mem_Stall cycle extends both points by one.
- A back-to-back MDU op can start in the cycle after Mdu_Done.
- Load-use costs exactly 1 stall cycle. Redirect costs 2 flushed slots.
- MDU_LATENCY==2: the op sees one stall cycle, then Mdu_Done.

## Structure
- State encodings `HZ_RUN and `HZ_MDU_WAIT, plus the MDU_LATENCY bounds, go in SYSTEM_DEF.vh alongside `ADDR_WIDTH.
- One sub-module, mdu_stall_timer, holds the FSM, cnt and Mdu_Done. The priority encoder and counters stay in the top level.

## Test plan
- Load-use: EX load with Rd=x5, ID reads Rs1=x5 with Used=1. Require one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Repeat with Rd=x0: no stall.
- MDU, MDU_LATENCY=4, Start at cycle 10: Require Mdu_Stall in cycles 10-12, Mdu_Done only in cycle 13, Stall_Cnt +3.
- Mem_Stall mid-MDU: Dmem_Ready=0 for 2 cycles during MDU_WAIT. Require cnt frozen and Mdu_Done delayed by 2. Require MEM_WB_Bubble=1 and EX_MEM_Write=0 in those cycles.
- Branch with a load-use in the same cycle: Require IF_ID_Flush=ID_EX_Flush=1, PC_Write=1, no stall, Flush_Cnt +1.
- Reset mid-MDU: assert rst in MDU_WAIT. Require state RUN, counters 0, all writes 1 immediately (asynchronous).
- Counter wrap: CNT_WIDTH=4, 17 stall cycles. Require Stall_Cnt = 1.
